// File: rtl/branch_predictor_gshare.sv
// Two-bit saturating-counter BHT plus direct-mapped tagged BTB for the fetch stage.
// Selectable bimodal (MODE 0) or gshare (MODE 1) BHT indexing; lookup is combinational.
module branch_predictor_gshare #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 4,
  parameter int GHR_W = 4,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  PC_curr,
  output logic [1:0]       prediction,
  output logic             btb_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  predicted_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic [PC_W-1:0]  upd_PC,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             wen_BHT,
  input  logic             wen_BTB,
  input  logic             actual_taken,
  input  logic [PC_W-1:0]  actual_target,
  input  logic             mispredict,
  input  logic             stat_clr,
  output logic [15:0]      stat_branches,
  output logic [15:0]      stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  if (GHR_W > IDX_W) begin : g_bad_ghr
    $error("branch_predictor_gshare: GHR_W must not exceed IDX_W");
  end

  logic [1:0]       bht        [ENTRIES];
  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [PC_W-1:0]  btb_target [ENTRIES];
  logic [GHR_W-1:0] ghr;

  logic [IDX_W-1:0] btb_idx, bht_idx, upd_btb_idx, upd_bht_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic [1:0]       upd_ctr;
  logic             upd_pc_unused;

  assign upd_pc_unused = ^{upd_PC[0], upd_PC[PC_W-1:IDX_W+TAG_W+1], upd_ghr};

  // Update indexing uses the history snapshot that travelled with the branch,
  // never the live GHR, so wrong-path history cannot skew training.
  always_comb begin
    btb_idx     = PC_curr[IDX_W:1];
    lk_tag      = PC_curr[IDX_W+TAG_W:IDX_W+1];
    upd_btb_idx = upd_PC[IDX_W:1];
    upd_tag     = upd_PC[IDX_W+TAG_W:IDX_W+1];
    if (MODE == 1) begin
      bht_idx     = btb_idx ^ IDX_W'(ghr);
      upd_bht_idx = upd_btb_idx ^ IDX_W'(upd_ghr);
    end else begin
      bht_idx     = btb_idx;
      upd_bht_idx = upd_btb_idx;
    end
  end

  always_comb begin
    prediction       = bht[bht_idx];
    btb_hit          = btb_valid[btb_idx] && (btb_tag[btb_idx] == lk_tag);
    pred_taken       = prediction[1] & btb_hit;
    predicted_target = btb_hit ? btb_target[btb_idx] : PC_curr + PC_W'(2);
    pred_ghr         = ghr;
  end

  always_comb begin
    upd_ctr = bht[upd_bht_idx];
    if (actual_taken && upd_ctr != 2'b11)
      upd_ctr = upd_ctr + 2'd1;
    else if (!actual_taken && upd_ctr != 2'b00)
      upd_ctr = upd_ctr - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        bht[IDX_W'(i)]        <= '0;
        btb_valid[IDX_W'(i)]  <= 1'b0;
        btb_tag[IDX_W'(i)]    <= '0;
        btb_target[IDX_W'(i)] <= '0;
      end
      ghr <= '0;
    end else begin
      if (wen_BHT) begin
        bht[upd_bht_idx] <= upd_ctr;
        ghr              <= {upd_ghr[GHR_W-2:0], actual_taken};
      end
      if (wen_BTB) begin
        btb_valid[upd_btb_idx]  <= 1'b1;
        btb_tag[upd_btb_idx]    <= upd_tag;
        btb_target[upd_btb_idx] <= actual_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (wen_BHT && stat_branches != '1)
        stat_branches <= stat_branches + 16'd1;
      if (mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised dynamic branch predictor for the fetch stage: 2-bit saturating-counter BHT plus tagged BTB, generalised in depth, tag width and indexing mode.
MODE 0 is bimodal (PC-indexed); MODE 1 is gshare (PC XOR global history).
- Lookup is combinational off the fetch PC.
- Update is synchronous, driven from decode via a pipelined PC and history snapshot.
- Saturating performance counters are included for accuracy measurement.

Parameters:
PC_W, 16, PC/target width; instructions are 2 bytes, so PC[0] is ignored.
IDX_W, 4, index width; 2^IDX_W BHT and BTB entries.
TAG_W, 4, BTB tag width; tag = PC[IDX_W+TAG_W:IDX_W+1].
GHR_W, 4, global history length; must be <= IDX_W (elaboration error otherwise).
MODE, 0, 0 = bimodal, 1 = gshare.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
PC_curr  in  PC_W  fetch PC to look up
prediction  out  2  BHT counter for lookup index; [1] = taken
btb_hit  out  1  BTB entry valid and tag match
pred_taken  out  1  prediction[1] & btb_hit
predicted_target  out  PC_W  BTB target if btb_hit, else PC_curr+2
pred_ghr  out  GHR_W  GHR used for this lookup; pipelined to decode
upd_PC  in  PC_W  PC of resolving branch
upd_ghr  in  GHR_W  pred_ghr snapshot travelling with that branch
wen_BHT  in  1  train BHT/GHR with actual_taken
wen_BTB  in  1  write BTB entry
actual_taken  in  1  resolved direction
actual_target  in  PC_W  resolved target
mispredict  in  1  decode flagged misprediction (stats only)
stat_clr  in  1  synchronous clear of stat counters
stat_branches  out  16  count of wen_BHT cycles
stat_mispredicts  out  16  count of mispredict cycles

Behaviour:
- Reset (rst==0 at posedge):
  - All BHT counters = 2'b00; all BTB valid = 0 (tag/target = 0); GHR = 0; stats = 0.
  - Outputs after reset: prediction=00, btb_hit=0, pred_taken=0, predicted_target=PC_curr+2, pred_ghr=0.
- Reset has priority over every write and stat_clr in the same cycle.
- Lookup (combinational, zero latency):
  - btb_idx = PC_curr[IDX_W:1].
  - bht_idx = btb_idx in MODE 0; btb_idx XOR zero-extended GHR in MODE 1.
  - pred_ghr = GHR (current register value) in both modes.
- Update (posedge, rst==1):
  - Update BTB index = upd_PC[IDX_W:1].
  - Update BHT index = same in MODE 0; XOR zero-extended upd_ghr in MODE 1. The live GHR is never used for update indexing.
  - wen_BHT with actual_taken=1: counter +1, saturating at 11.
  - wen_BHT with actual_taken=0: counter -1, saturating at 00.
  - wen_BHT also shifts GHR: GHR <= {upd_ghr[GHR_W-2:0], actual_taken}. This restores from the snapshot, so wrong-path history is discarded. The shift occurs in MODE 0 too, but GHR is unused there.
  - wen_BTB: entry <= {valid=1, tag(upd_PC), actual_target}. An existing entry with a different tag is overwritten (direct-mapped replacement).
  - wen_BHT and wen_BTB are independent and may assert together.
- Same-cycle lookup and update to the same index: no bypass. Lookup returns the pre-update value; the new value is visible the cycle after the edge.
- Stats:
  - Each counter +1 per qualifying cycle, saturating at 16'hFFFF with no wrap.
  - stat_clr zeroes both; stat_clr wins over an increment in the same cycle.
- PC arithmetic: PC_curr+2 is modulo 2^PC_W, so 16'hFFFE -> 16'h0000.
- X on the write-enable inputs during rst==0 must not corrupt state after reset deasserts.

Test Plan:
1. Reset: rst=0 for 1 cycle, then PC_curr=16'h0010 -> prediction=00, btb_hit=0, predicted_target=16'h0012, both stats=0.
2. Counter saturation (MODE 0): 4x wen_BHT at upd_PC=16'h0004, actual_taken=1 -> prediction at PC 0x0004 steps 01, 10, 11, 11. Then one not-taken -> 10. stat_branches=5.
3. BTB tag/alias: wen_BTB at upd_PC=16'h0004, target 16'h0040, with counter=11.
   - PC_curr=16'h0004 -> btb_hit=1, pred_taken=1, predicted_target=16'h0040.
   - PC_curr=16'h0024 (same index, tag differs) -> btb_hit=0, predicted_target=16'h0026.
4. Same-cycle hazard: PC_curr=16'h0008 held, wen_BHT taken at upd_PC=16'h0008 -> prediction=00 in the write cycle, 01 in the next cycle.
5. Gshare indexing (MODE 1):
   - Two taken updates with upd_ghr chained from 0 -> GHR=4'b0011.
   - PC_curr=16'h0002 (btb_idx 1) -> reads BHT entry 2; pred_ghr=0011.
   - Taken update with upd_PC=16'h0002, upd_ghr=0011 -> entry 2 becomes 01; entry 1 is unchanged.
   - A later update with upd_ghr=0000 sets GHR=0000|taken=0001, proving restore from the snapshot.
6. Stats: preload both counters to 16'hFFFE via repeated pulses; 3 further mispredict pulses -> stat_mispredicts=16'hFFFF. stat_clr together with mispredict -> both counters 0.
